alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 188 ++++++++++++++++++
 tb/tb_alarm_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Alarm-clock sequencer. It watches the current time against the alarm time
// and rings on the first cycle of a matching minute. It supports a limited
// number of snoozes per alarm event and can optionally stop ringing by itself
// after a timeout.
//
// Parameters:
//   SNOOZE_SEC        snooze duration, in i_Sec_Tick pulses
//   RING_TIMEOUT_SEC  ring auto-stop duration, in i_Sec_Tick pulses
//   MAX_SNOOZE        maximum snoozes per alarm event (must fit in 2 bits)
//
// Optional feature macro:
//   ALARM_CTRL_AUTO_STOP_EN  when defined, RINGING returns to ARMED after
//                            RING_TIMEOUT_SEC ticks. When undefined, the ring
//                            timer is not built, and RINGING lasts until stop,
//                            snooze or disable.
//
// Ports:
//   i_Clk           system clock, rising edge
//   i_Rst_L         asynchronous active-low reset
//   i_Sec_Tick      one-cycle pulse per second
//   i_Cur_Hour/Min  current time (0-23 / 0-59)
//   i_Alarm_Hour/Min alarm time (0-23 / 0-59)
//   i_Alarm_Enable  level, alarm armed while high
//   i_Snooze        one-cycle snooze request
//   i_Stop          one-cycle stop request
//   o_Alarm_On      registered, high while ringing
//   o_State         IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
//   o_Snooze_Cnt    snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_controller #(
  parameter int SNOOZE_SEC       = 540,
  parameter int RING_TIMEOUT_SEC = 300,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Sec_Tick,
  input  logic [4:0] i_Cur_Hour,
  input  logic [5:0] i_Cur_Min,
  input  logic [4:0] i_Alarm_Hour,
  input  logic [5:0] i_Alarm_Min,
  input  logic       i_Alarm_Enable,
  input  logic       i_Snooze,
  input  logic       i_Stop,
  output logic       o_Alarm_On,
  output logic [1:0] o_State,
  output logic [1:0] o_Snooze_Cnt
);

  localparam int SNZ_W = $clog2(SNOOZE_SEC + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_SEC);
  localparam logic [1:0]       CNT_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             match_reg;
  logic [SNZ_W-1:0] snz_timer_reg, snz_timer_next;
  logic [1:0]       snz_cnt_reg, snz_cnt_next;
  logic             alarm_on_reg;

`ifdef ALARM_CTRL_AUTO_STOP_EN
  localparam int RING_W = $clog2(RING_TIMEOUT_SEC + 1);
  // Ring timer value at which the next tick completes the timeout.
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);
  logic [RING_W-1:0] ring_timer_reg, ring_timer_next;
`endif

  logic match;
  logic match_rise;

  assign match      = (i_Cur_Hour == i_Alarm_Hour) && (i_Cur_Min == i_Alarm_Min);
  // Only the first cycle of a matching minute triggers the alarm.
  assign match_rise = match && !match_reg;

  // Next-state logic. The priority order is: disable, stop, snooze,
  // ring timeout, snooze expiry, match edge.
  always_comb begin
    state_next     = state_reg;
    snz_timer_next = snz_timer_reg;
    snz_cnt_next   = snz_cnt_reg;
`ifdef ALARM_CTRL_AUTO_STOP_EN
    ring_timer_next = ring_timer_reg;
`endif

    if (!i_Alarm_Enable) begin
      state_next     = IDLE;
      snz_timer_next = '0;
      snz_cnt_next   = '0;
`ifdef ALARM_CTRL_AUTO_STOP_EN
      ring_timer_next = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: state_next = ARMED;

        ARMED: begin
          if (match_rise) begin
            state_next     = RINGING;
            snz_timer_next = '0;
`ifdef ALARM_CTRL_AUTO_STOP_EN
            ring_timer_next = '0;
`endif
          end
        end

        RINGING: begin
          if (i_Stop) begin
            state_next   = ARMED;
            snz_cnt_next = '0;
          end else if (i_Snooze && (snz_cnt_reg < CNT_MAX)) begin
            state_next     = SNOOZE;
            snz_timer_next = SNZ_LOAD;
            snz_cnt_next   = snz_cnt_reg + 2'd1;
          end
`ifdef ALARM_CTRL_AUTO_STOP_EN
          else if (i_Sec_Tick) begin
            if (ring_timer_reg >= RING_LAST) begin
              state_next      = ARMED;
              snz_cnt_next    = '0;
              ring_timer_next = '0;
            end else begin
              ring_timer_next = ring_timer_reg + 1'b1;
            end
          end
`endif
        end

        SNOOZE: begin
          if (i_Stop) begin
            state_next     = ARMED;
            snz_cnt_next   = '0;
            snz_timer_next = '0;
          end else if (i_Sec_Tick) begin
            if (snz_timer_reg == SNZ_W'(1)) begin
              state_next     = RINGING;
              snz_timer_next = '0;
`ifdef ALARM_CTRL_AUTO_STOP_EN
              ring_timer_next = '0;
`endif
            end else if (snz_timer_reg != '0) begin
              snz_timer_next = snz_timer_reg - 1'b1;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // The match register resets to 1, so a time that already matches when
  // reset is released is not seen as a new edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg     <= IDLE;
      match_reg     <= 1'b1;
      snz_timer_reg <= '0;
      snz_cnt_reg   <= '0;
      alarm_on_reg  <= 1'b0;
`ifdef ALARM_CTRL_AUTO_STOP_EN
      ring_timer_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      match_reg     <= match;
      snz_timer_reg <= snz_timer_next;
      snz_cnt_reg   <= snz_cnt_next;
      alarm_on_reg  <= (state_next == RINGING);
`ifdef ALARM_CTRL_AUTO_STOP_EN
      ring_timer_reg <= ring_timer_next;
`endif
    end
  end

  assign o_Alarm_On   = alarm_on_reg;
  assign o_State      = state_reg;
  assign o_Snooze_Cnt = snz_cnt_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
//
// Directed bench for alarm_controller with SNOOZE_SEC=4, RING_TIMEOUT_SEC=5
// and MAX_SNOOZE=3. Inputs change 1 ns after a rising edge. Outputs are
// sampled 1 ns after the edge that follows. The timeout check follows
// ALARM_CTRL_AUTO_STOP_EN.
// -----------------------------------------------------------------------------
module tb_alarm_controller;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sec_tick, snooze, stop, enable;
  logic [4:0] cur_hour, alarm_hour;
  logic [5:0] cur_min, alarm_min;
  logic       alarm_on;
  logic [1:0] state, snz_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alarm_controller #(
    .SNOOZE_SEC(4),
    .RING_TIMEOUT_SEC(5),
    .MAX_SNOOZE(3)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Sec_Tick(sec_tick),
    .i_Cur_Hour(cur_hour),
    .i_Cur_Min(cur_min),
    .i_Alarm_Hour(alarm_hour),
    .i_Alarm_Min(alarm_min),
    .i_Alarm_Enable(enable),
    .i_Snooze(snooze),
    .i_Stop(stop),
    .o_Alarm_On(alarm_on),
    .o_State(state),
    .o_Snooze_Cnt(snz_cnt)
  );

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, observed, expected);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    clk1();
    sec_tick = 1'b0;
    clk1();
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    clk1();
    snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    clk1();
    stop = 1'b0;
  endtask

  // Leave the alarm minute, then re-enter it so that the match register sees
  // a fresh rising edge.
  task automatic retrigger();
    cur_min = 6'd31;
    clk1();
    cur_min = 6'd30;
    clk1();
  endtask

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0; enable = 1'b0;
    cur_hour = 5'd7; cur_min = 6'd29; alarm_hour = 5'd7; alarm_min = 6'd30;
    clk1(); clk1();
    check("reset_state", state, S_IDLE);
    check("reset_alarm_on", alarm_on, 0);
    check("reset_snz_cnt", snz_cnt, 0);
    rst_n = 1'b1;
    clk1();
    check("idle_no_enable", state, S_IDLE);

    enable = 1'b1;
    clk1();
    check("enable_armed", state, S_ARMED);
    clk1();
    check("armed_hold", state, S_ARMED);

    // 07:29 -> 07:30
    cur_min = 6'd30;
    clk1();
    check("match_ringing", state, S_RING);
    check("match_alarm_on", alarm_on, 1);

    // Three full snooze cycles
    for (int s = 1; s <= 3; s++) begin
      pulse_snooze();
      check("snooze_state", state, S_SNZ);
      check("snooze_cnt", snz_cnt, s);
      check("snooze_alarm_off", alarm_on, 0);
      tick(); tick(); tick();
      check("snooze_after3", state, S_SNZ);
      tick();
      check("snooze_expired", state, S_RING);
      check("snooze_expired_on", alarm_on, 1);
    end

    pulse_snooze();
    check("snooze_at_max_state", state, S_RING);
    check("snooze_at_max_cnt", snz_cnt, 3);

    pulse_stop();
    check("stop_state", state, S_ARMED);
    check("stop_cnt", snz_cnt, 0);
    check("stop_alarm_off", alarm_on, 0);
    clk1(); clk1(); clk1();
    check("no_retrigger_same_min", state, S_ARMED);

    // Stop and snooze together: stop has priority
    retrigger();
    check("retrigger_ring", state, S_RING);
    stop = 1'b1; snooze = 1'b1;
    clk1();
    stop = 1'b0; snooze = 1'b0;
    check("stop_beats_snooze", state, S_ARMED);
    check("stop_beats_snooze_cnt", snz_cnt, 0);

    // Disable together with stop: disable has priority
    retrigger();
    check("retrigger_ring2", state, S_RING);
    enable = 1'b0; stop = 1'b1;
    clk1();
    stop = 1'b0;
    check("disable_idle", state, S_IDLE);
    check("disable_alarm_off", alarm_on, 0);
    enable = 1'b1;
    clk1(); clk1();
    check("reenable_no_trigger", state, S_ARMED);

    // Ring timeout
    retrigger();
    check("timeout_ring", state, S_RING);
    tick(); tick(); tick(); tick();
    check("timeout_after4", state, S_RING);
    tick();
`ifdef ALARM_CTRL_AUTO_STOP_EN
    check("timeout_armed", state, S_ARMED);
    check("timeout_alarm_off", alarm_on, 0);
`else
    check("no_timeout_after5", state, S_RING);
    tick(); tick(); tick(); tick(); tick();
    check("no_timeout_after10", state, S_RING);
`endif
    pulse_stop();
    check("pre_snooze_armed", state, S_ARMED);

    // Snooze ignored and stop honoured while in SNOOZE
    retrigger();
    pulse_snooze();
    check("snz2_state", state, S_SNZ);
    pulse_snooze();
    check("snz_ignored_state", state, S_SNZ);
    check("snz_ignored_cnt", snz_cnt, 1);
    pulse_stop();
    check("snz_stop_state", state, S_ARMED);
    check("snz_stop_cnt", snz_cnt, 0);

    // Asynchronous reset mid-ring, between clock edges
    retrigger();
    check("pre_reset_on", alarm_on, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_alarm_off", alarm_on, 0);
    check("async_reset_idle", state, S_IDLE);
    #3 rst_n = 1'b1;
    clk1(); clk1(); clk1();
    check("release_match_no_trigger", state, S_ARMED);
    check("release_alarm_off", alarm_on, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
